// File: rtl/flag_cond_unit.sv
// flag_cond_unit: NZCV flag register, saved-flags slot and condition evaluator.
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   alu_status[3:0]   : {N,Z,C,V} from the ALU for the executing instruction
//   update_en         : executing instruction sets flags
//   flush             : kills update_en and cond_valid this cycle
//   cond_valid, cond  : condition evaluation request and ARM-style code
//   save_req          : copy registered flags into the saved slot
//   restore_req       : load flags from the saved slot
//   flags, saved_flags: registered NZCV and saved slot
//   carry_out         : registered C flag, to the ALU carry input
//   cond_done         : result valid, one cycle after an unflushed request
//   cond_pass         : condition result, 0 whenever cond_done is 0
module flag_cond_unit #(
   parameter logic [3:0] RESET_FLAGS = 4'b0000,
   parameter bit         FORWARD     = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] alu_status,
   input  logic       update_en,
   input  logic       flush,
   input  logic       cond_valid,
   input  logic [3:0] cond,
   input  logic       save_req,
   input  logic       restore_req,
   output logic [3:0] flags,
   output logic [3:0] saved_flags,
   output logic       carry_out,
   output logic       cond_done,
   output logic       cond_pass
);

   logic [3:0] flags_nxt;
   logic [3:0] saved_nxt;
   logic [3:0] eff;
   logic       upd_ok;
   logic       req_ok;
   logic       n, z, c, v;
   logic       base;
   logic       pass;

   assign upd_ok = update_en & ~flush;
   assign req_ok = cond_valid & ~flush;

   always_comb begin
      flags_nxt = flags;
      if (restore_req) begin
         flags_nxt = saved_flags;
      end else if (upd_ok) begin
         flags_nxt = alu_status;
      end
   end

   // saved slot always captures the old registered value, so a
   // save with a concurrent restore becomes a swap
   always_comb begin
      saved_nxt = saved_flags;
      if (save_req) begin
         saved_nxt = flags;
      end
   end

   assign eff = FORWARD ? flags_nxt : flags;
   assign {n, z, c, v} = eff;

   // cond[3:1] picks the base test; cond[0] inverts it.
   // AL (1110) is base 1 so NV (1111) inverts to 0.
   always_comb begin
      base = 1'b0;
      unique case (cond[3:1])
         3'b000: base = z;
         3'b001: base = c;
         3'b010: base = n;
         3'b011: base = v;
         3'b100: base = c & ~z;
         3'b101: base = ~(n ^ v);
         3'b110: base = ~z & ~(n ^ v);
         3'b111: base = 1'b1;
         default: base = 1'b0;
      endcase
      pass = base ^ cond[0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags       <= RESET_FLAGS;
         saved_flags <= RESET_FLAGS;
         cond_done   <= 1'b0;
         cond_pass   <= 1'b0;
      end else begin
         flags       <= flags_nxt;
         saved_flags <= saved_nxt;
         cond_done   <= req_ok;
         cond_pass   <= req_ok & pass;
      end
   end

   // never forwarded: keeps the ALU carry path loop-free
   assign carry_out = flags[1];

endmodule

// File: tb/tb_flag_cond_unit.sv
// tb_flag_cond_unit: scoreboard bench for flag_cond_unit.
// Drives a FORWARD=1 and a FORWARD=0 instance from the same stimulus.
module tb_flag_cond_unit;

   logic       clk;
   logic       rst;
   logic [3:0] alu_status;
   logic       update_en;
   logic       flush;
   logic       cond_valid;
   logic [3:0] cond;
   logic       save_req;
   logic       restore_req;

   logic [3:0] flags1, saved1, flags0, saved0;
   logic       carry1, done1, pass1, carry0, done0, pass0;

   int n_chk;
   int n_err;

   logic [3:0] mf;
   logic [3:0] ms;

   logic [1:0] q1[$];
   logic [1:0] q0[$];

   flag_cond_unit #(.RESET_FLAGS(4'b0000), .FORWARD(1'b1)) dut1 (
      .clk(clk), .rst(rst), .alu_status(alu_status),
      .update_en(update_en), .flush(flush),
      .cond_valid(cond_valid), .cond(cond),
      .save_req(save_req), .restore_req(restore_req),
      .flags(flags1), .saved_flags(saved1), .carry_out(carry1),
      .cond_done(done1), .cond_pass(pass1)
   );

   flag_cond_unit #(.RESET_FLAGS(4'b0000), .FORWARD(1'b0)) dut0 (
      .clk(clk), .rst(rst), .alu_status(alu_status),
      .update_en(update_en), .flush(flush),
      .cond_valid(cond_valid), .cond(cond),
      .save_req(save_req), .restore_req(restore_req),
      .flags(flags0), .saved_flags(saved0), .carry_out(carry0),
      .cond_done(done0), .cond_pass(pass0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] got,
                      input logic [3:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic tbl(input logic [3:0] f, input logic [3:0] cc);
      logic fn, fz, fc, fv;
      {fn, fz, fc, fv} = f;
      case (cc)
         4'h0: tbl = fz;
         4'h1: tbl = !fz;
         4'h2: tbl = fc;
         4'h3: tbl = !fc;
         4'h4: tbl = fn;
         4'h5: tbl = !fn;
         4'h6: tbl = fv;
         4'h7: tbl = !fv;
         4'h8: tbl = fc && !fz;
         4'h9: tbl = !fc || fz;
         4'hA: tbl = (fn == fv);
         4'hB: tbl = (fn != fv);
         4'hC: tbl = !fz && (fn == fv);
         4'hD: tbl = fz || (fn != fv);
         4'hE: tbl = 1'b1;
         default: tbl = 1'b0;
      endcase
   endfunction

   task automatic cyc(input logic upd, input logic [3:0] st,
                      input logic fl, input logic cv, input logic [3:0] cc,
                      input logic sv, input logic rs);
      logic [3:0] fn_m, sn_m;
      logic [1:0] e1, e0, g;
      @(negedge clk);
      alu_status  = st;
      update_en   = upd;
      flush       = fl;
      cond_valid  = cv;
      cond        = cc;
      save_req    = sv;
      restore_req = rs;
      fn_m = rs ? ms : ((upd && !fl) ? st : mf);
      sn_m = sv ? mf : ms;
      q1.push_back({cv && !fl, cv && !fl && tbl(fn_m, cc)});
      q0.push_back({cv && !fl, cv && !fl && tbl(mf, cc)});
      #1;
      chk("carry_pre", {3'b0, carry1}, {3'b0, mf[1]});
      @(posedge clk);
      #1;
      mf = fn_m;
      ms = sn_m;
      chk("flags1", flags1, mf);
      chk("saved1", saved1, ms);
      chk("flags0", flags0, mf);
      chk("carry1", {3'b0, carry1}, {3'b0, mf[1]});
      e1 = q1.pop_front();
      e0 = q0.pop_front();
      g = {done1, pass1};
      chk($sformatf("cond1_%h", cc), {2'b0, g}, {2'b0, e1});
      g = {done0, pass0};
      chk($sformatf("cond0_%h", cc), {2'b0, g}, {2'b0, e0});
   endtask

   task automatic idle();
      cyc(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      mf = 4'h0;
      ms = 4'h0;
      rst = 1'b1;
      alu_status = 4'h0;
      update_en = 1'b0;
      flush = 1'b0;
      cond_valid = 1'b0;
      cond = 4'h0;
      save_req = 1'b0;
      restore_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_flags", flags1, 4'h0);
      chk("rst_saved", saved1, 4'h0);
      chk("rst_done", {3'b0, done1}, 4'h0);
      @(negedge clk);
      rst = 1'b0;

      // forwarding: Z set and EQ evaluated in the same cycle
      cyc(1'b1, 4'b0100, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
      chk("fwd1_pass", {3'b0, pass1}, 4'h1);
      chk("fwd0_pass", {3'b0, pass0}, 4'h0);

      // full table sweep
      for (int f = 0; f < 16; f++) begin
         cyc(1'b1, 4'(f), 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
         for (int k = 0; k < 16; k++) begin
            cyc(1'b0, 4'h0, 1'b0, 1'b1, 4'(k), 1'b0, 1'b0);
         end
      end

      // flush from flags 0000
      cyc(1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      cyc(1'b1, 4'b1111, 1'b1, 1'b1, 4'hE, 1'b0, 1'b0);
      chk("flush_flags", flags1, 4'h0);
      chk("flush_done", {3'b0, done1}, 4'h0);
      chk("flush_carry", {3'b0, carry1}, 4'h0);

      // save/restore
      cyc(1'b1, 4'b0010, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      cyc(1'b1, 4'b1000, 1'b0, 1'b1, 4'h4, 1'b1, 1'b0);
      chk("sv_saved", saved1, 4'b0010);
      chk("sv_flags", flags1, 4'b1000);
      cyc(1'b1, 4'b0001, 1'b0, 1'b1, 4'h2, 1'b0, 1'b1);
      chk("rs_flags", flags1, 4'b0010);
      cyc(1'b1, 4'b0100, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1);
      chk("swap_flags", flags1, 4'b0010);
      chk("swap_saved", saved1, 4'b0100);
      // restore still applies under flush
      cyc(1'b1, 4'b1111, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1);
      chk("fl_rs_flags", flags1, 4'b0100);

      // carry feedback
      cyc(1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      cyc(1'b1, 4'b0010, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("carry_set", {3'b0, carry1}, 4'h1);
      idle();
      chk("carry_hold", {3'b0, carry1}, 4'h1);

      // random back-to-back traffic
      for (int i = 0; i < 300; i++) begin
         cyc(1'($urandom), 4'($urandom), 1'($urandom_range(0, 3) == 0),
             1'($urandom), 4'($urandom),
             1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0));
      end

      // async reset mid-cycle with a result pending
      cyc(1'b1, 4'b1010, 1'b0, 1'b1, 4'hE, 1'b1, 1'b0);
      cyc(1'b1, 4'b0110, 1'b0, 1'b1, 4'hE, 1'b1, 1'b0);
      @(negedge clk);
      update_en = 1'b0;
      cond_valid = 1'b0;
      save_req = 1'b0;
      restore_req = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_flags", flags1, 4'h0);
      chk("arst_saved", saved1, 4'h0);
      chk("arst_done", {3'b0, done1}, 4'h0);
      chk("arst_flags0", flags0, 4'h0);
      mf = 4'h0;
      ms = 4'h0;
      q1.delete();
      q0.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
      chk("post_rst_ne", {2'b0, done1, pass1}, 4'b0011);
      idle();
      chk("idle_done", {3'b0, done1}, 4'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
